// File: rtl/reg_file.sv
// RV32IM integer register file: 32 x 32-bit, x0 reads as zero, two combinational read ports, one write port.
// Define REG_FILE_BYPASS_EN to forward the in-flight write data to a read port addressing the same register.
module reg_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              ip_clk,
  input  logic              ip_rst,
  input  logic              ip_wr_en,
  input  logic [ADDR_W-1:0] ip_rd_addr,
  input  logic [DATA_W-1:0] ip_wr_data,
  input  logic [ADDR_W-1:0] ip_rs1_addr,
  input  logic [ADDR_W-1:0] ip_rs2_addr,
  output logic [DATA_W-1:0] op_rs1,
  output logic [DATA_W-1:0] op_rs2
);

  logic [DATA_W-1:0] reg_q [NUM_REGS];

  // The asynchronous clear rules out block RAM, so each register is its own flop bank.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign reg_q[gi] = '0;
    end else begin : g_store
      logic [DATA_W-1:0] q;
      always_ff @(posedge ip_clk or posedge ip_rst) begin
        if (ip_rst) begin
          q <= '0;
        end else if (ip_wr_en && (ip_rd_addr == ADDR_W'(gi))) begin
          q <= ip_wr_data;
        end
      end
      assign reg_q[gi] = q;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  logic fwd_rs1;
  logic fwd_rs2;

  // Stored contents are already zero under reset; forwarding must be blocked too.
  assign fwd_rs1 = !ip_rst && ip_wr_en && (ip_rd_addr != '0) && (ip_rs1_addr == ip_rd_addr);
  assign fwd_rs2 = !ip_rst && ip_wr_en && (ip_rd_addr != '0) && (ip_rs2_addr == ip_rd_addr);

  always_comb begin
    op_rs1 = fwd_rs1 ? ip_wr_data : reg_q[ip_rs1_addr];
    op_rs2 = fwd_rs2 ? ip_wr_data : reg_q[ip_rs2_addr];
  end
`else
  always_comb begin
    op_rs1 = reg_q[ip_rs1_addr];
    op_rs2 = reg_q[ip_rs2_addr];
  end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus pushes expected read values, a negedge monitor compares them.
// Honours REG_FILE_BYPASS_EN the same way the design does.
module tb_reg_file;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              ip_clk = 1'b0;
  logic              ip_rst = 1'b1;
  logic              ip_wr_en = 1'b0;
  logic [ADDR_W-1:0] ip_rd_addr = '0;
  logic [DATA_W-1:0] ip_wr_data = '0;
  logic [ADDR_W-1:0] ip_rs1_addr = '0;
  logic [ADDR_W-1:0] ip_rs2_addr = '0;
  logic [DATA_W-1:0] op_rs1;
  logic [DATA_W-1:0] op_rs2;

  reg_file dut (
    .ip_clk      (ip_clk),
    .ip_rst      (ip_rst),
    .ip_wr_en    (ip_wr_en),
    .ip_rd_addr  (ip_rd_addr),
    .ip_wr_data  (ip_wr_data),
    .ip_rs1_addr (ip_rs1_addr),
    .ip_rs2_addr (ip_rs2_addr),
    .op_rs1      (op_rs1),
    .op_rs2      (op_rs2)
  );

  always #5 ip_clk = ~ip_clk;

  typedef struct {
    string            name;
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    logic [DATA_W-1:0] e1;
    logic [DATA_W-1:0] e2;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: plain array of architectural register contents.
  logic [DATA_W-1:0] model [32];

  function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a, input logic rst,
                                                 input logic we, input logic [ADDR_W-1:0] rd,
                                                 input logic [DATA_W-1:0] d);
    if (rst || a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (we && rd != 0 && a == rd) return d;
`endif
    return model[a];
  endfunction

  // Monitor: outputs are combinational, so sample them mid-cycle at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge ip_clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (op_rs1 !== e.e1) begin
          n_fail++;
          $display("FAIL %s rs1 x%0d got %h expected %h", e.name, e.a1, op_rs1, e.e1);
        end else begin
          $display("ok   %s rs1 x%0d = %h", e.name, e.a1, op_rs1);
        end
        n_checks++;
        if (op_rs2 !== e.e2) begin
          n_fail++;
          $display("FAIL %s rs2 x%0d got %h expected %h", e.name, e.a2, op_rs2, e.e2);
        end else begin
          $display("ok   %s rs2 x%0d = %h", e.name, e.a2, op_rs2);
        end
      end
    end
  end

  // One clock cycle of stimulus; called just after a rising edge, returns just after the next one.
  task automatic cycle(input string name, input logic rst, input logic we,
                       input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d,
                       input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    exp_t e;
    ip_rst = rst; ip_wr_en = we; ip_rd_addr = rd; ip_wr_data = d;
    ip_rs1_addr = r1; ip_rs2_addr = r2;
    if (rst) foreach (model[i]) model[i] = '0;
    e.name = name; e.a1 = r1; e.a2 = r2;
    e.e1 = exp_read(r1, rst, we, rd, d);
    e.e2 = exp_read(r2, rst, we, rd, d);
    sb.push_back(e);
    @(posedge ip_clk);
    #1;
    if (!rst && we && rd != 0) model[rd] = d;
  endtask

  // Reset pulsed between edges: checked while held, released before the next edge.
  task automatic mid_reset(input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    exp_t e;
    ip_wr_en = 1'b0; ip_rs1_addr = r1; ip_rs2_addr = r2;
    #1 ip_rst = 1'b1;
    foreach (model[i]) model[i] = '0;
    e.name = "mid_reset_held"; e.a1 = r1; e.a2 = r2; e.e1 = '0; e.e2 = '0;
    sb.push_back(e);
    @(negedge ip_clk);
    #1 ip_rst = 1'b0;
    @(posedge ip_clk);
    #1;
  endtask

  initial begin
    logic [ADDR_W-1:0] rd, r1, r2;
    logic              we;
    foreach (model[i]) model[i] = '0;
    @(posedge ip_clk);
    #1;
    cycle("reset_hold", 1'b1, 1'b1, 5'd3, 32'h1234_5678, 5'd3, 5'd31);
    cycle("reset_rel",  1'b0, 1'b0, 5'd0, 32'h0,        5'd3, 5'd17);

    cycle("wr_x5", 1'b0, 1'b1, 5'd5, 32'd1, 5'd1, 5'd2);
    cycle("wr_x6", 1'b0, 1'b1, 5'd6, 32'd2, 5'd5, 5'd0);
    cycle("wr_x7", 1'b0, 1'b1, 5'd7, 32'd3, 5'd6, 5'd5);
    cycle("wr_x8", 1'b0, 1'b1, 5'd8, 32'd4, 5'd7, 5'd7);
    cycle("rd_5_6", 1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
    cycle("rd_7_8", 1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd8);

    cycle("wr_x0",   1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0);
    cycle("rd_x0",   1'b0, 1'b0, 5'd0, 32'h0,        5'd0, 5'd5);
    cycle("we_low",  1'b0, 1'b0, 5'd5, 32'hFFFF,     5'd5, 5'd5);
    cycle("rd_x5",   1'b0, 1'b0, 5'd0, 32'h0,        5'd5, 5'd8);

    cycle("same_cycle_x9", 1'b0, 1'b1, 5'd9, 32'h55, 5'd9, 5'd8);
    cycle("after_x9",      1'b0, 1'b0, 5'd0, 32'h0,  5'd9, 5'd9);

    mid_reset(5'd5, 5'd6);
    cycle("post_reset_5_6", 1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
    cycle("post_reset_7_8", 1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd8);

    for (int i = 0; i < 400; i++) begin
      we = ($urandom_range(0, 3) != 0);
      rd = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      cycle("random", ($urandom_range(0, 79) == 0), we, rd, $urandom, r1, r2);
    end

    @(posedge ip_clk);
    @(posedge ip_clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left %0d expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
